// File: rtl/vector_processor_pipe.sv
// Vector processor: vector memory + register file with LOAD/STORE/ADD/MUL (SUB when VP_SUB_EN is defined).
// Latency: a command accepted at edge N runs BEATS=VEC_LEN/LANES beats; done/err pulse the cycle after edge N+BEATS.
// Backpressure: cmd_ready is low for the whole EXEC phase; host writes are dropped unless IDLE with no command accepted.
module vector_processor_pipe #(
   parameter int WORD_W   = 32,
   parameter int VEC_LEN  = 16,
   parameter int MEM_VECS = 32,
   parameter int RF_DEPTH = 4,
   parameter int LANES    = 4   // VEC_LEN must be a multiple of LANES
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                cmd_valid,
   output logic                                cmd_ready,
   input  logic [2:0]                          opcode,
   input  logic [$clog2(RF_DEPTH)-1:0]         src_a,
   input  logic [$clog2(RF_DEPTH)-1:0]         src_b,
   input  logic [$clog2(RF_DEPTH)-1:0]         dst,
   input  logic [$clog2(MEM_VECS)-1:0]         mem_vec,
   output logic                                done,
   output logic                                err,
   input  logic                                host_we,
   input  logic [$clog2(MEM_VECS*VEC_LEN)-1:0] host_addr,
   input  logic [WORD_W-1:0]                   host_wdata,
   input  logic [$clog2(MEM_VECS*VEC_LEN)-1:0] dbg_addr,
   output logic [WORD_W-1:0]                   dbg_rdata
);

   localparam int BEATS = VEC_LEN / LANES;
   localparam int DEPTH = MEM_VECS * VEC_LEN;
   localparam int AW    = $clog2(DEPTH);
   localparam int RW    = $clog2(RF_DEPTH);
   localparam int VW    = $clog2(MEM_VECS);
   localparam int EW    = $clog2(VEC_LEN);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_MUL   = 3'd1;
   localparam logic [2:0] OP_LOAD  = 3'd2;
   localparam logic [2:0] OP_STORE = 3'd3;
`ifdef VP_SUB_EN
   localparam logic [2:0] OP_SUB   = 3'd4;
   localparam logic [2:0] OP_LAST  = 3'd4;
`else
   localparam logic [2:0] OP_LAST  = 3'd3;
`endif

   localparam logic [RW-1:0] LO_R = RW'(RF_DEPTH - 2);
   localparam logic [RW-1:0] HI_R = RW'(RF_DEPTH - 1);

   typedef enum logic {S_IDLE, S_EXEC} state_t;

   state_t          state_q;
   logic [BW-1:0]   beat_q;
   logic            done_q, err_q;
   logic [2:0]      op_q;
   logic [RW-1:0]   src_a_q, src_b_q, dst_q;
   logic [VW-1:0]   mem_vec_q;
   logic            illegal;

   logic [WORD_W-1:0] rf_q [RF_DEPTH][VEC_LEN];
   logic [WORD_W-1:0] rf_d [RF_DEPTH][VEC_LEN];
   logic [WORD_W-1:0] mem  [DEPTH];

   logic              exec, accept, host_ok, dbg_ok, host_wr, st_we;
   logic [AW-1:0]     st_addr [LANES];
   logic [WORD_W-1:0] st_dat  [LANES];
   logic [EW-1:0]     e;
   logic [AW-1:0]     m_addr;
   logic [WORD_W-1:0] a, b, lo, hi;
   logic [WORD_W:0]   sum;
   logic [2*WORD_W-1:0] prod;
`ifdef VP_SUB_EN
   logic [WORD_W-1:0] diff;
`endif
   logic              wr_res;
   logic [WORD_W-1:0] dbg_rdata_d, dbg_rdata_q;

   assign exec      = (state_q == S_EXEC);
   assign cmd_ready = (state_q == S_IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign host_wr   = host_we && cmd_ready && !cmd_valid && host_ok;
   assign done      = done_q;
   assign err       = err_q;
   assign dbg_rdata = dbg_rdata_q;

   // Out-of-range addresses can only exist when the memory is not a power of two deep.
   if (DEPTH == (1 << AW)) begin : g_full_range
      assign host_ok = 1'b1;
      assign dbg_ok  = 1'b1;
   end else begin : g_part_range
      assign host_ok = (host_addr < AW'(DEPTH));
      assign dbg_ok  = (dbg_addr  < AW'(DEPTH));
   end

   // Opcodes beyond the last implemented one run the beats silently and flag err.
   always_comb begin
      illegal = (op_q > OP_LAST);
   end

   // Command FSM: latch the command on accept, count beats, pulse done/err on the last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         beat_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         op_q      <= '0;
         src_a_q   <= '0;
         src_b_q   <= '0;
         dst_q     <= '0;
         mem_vec_q <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_q      <= opcode;
                  src_a_q   <= src_a;
                  src_b_q   <= src_b;
                  dst_q     <= dst;
                  mem_vec_q <= mem_vec;
                  beat_q    <= '0;
                  state_q   <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (beat_q == BW'(BEATS - 1)) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
                  err_q   <= illegal;
               end else begin
                  beat_q <= beat_q + BW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Lane datapath: each beat touches only its own LANES elements, so operands read from rf_q
   // are always the pre-command values even when a source is also a result register.
   always_comb begin
      rf_d   = rf_q;
      st_we  = 1'b0;
      e      = '0;
      m_addr = '0;
      a      = '0;
      b      = '0;
      lo     = '0;
      hi     = '0;
      sum    = '0;
      prod   = '0;
`ifdef VP_SUB_EN
      diff   = '0;
`endif
      wr_res = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         st_addr[l] = '0;
         st_dat[l]  = '0;
      end
      for (int l = 0; l < LANES; l++) begin
         e      = EW'(int'(beat_q) * LANES + l);
         m_addr = AW'(int'(mem_vec_q) * VEC_LEN + int'(e));
         a      = rf_q[src_a_q][e];
         b      = rf_q[src_b_q][e];
         sum    = {1'b0, a} + {1'b0, b};
         prod   = {{WORD_W{1'b0}}, a} * {{WORD_W{1'b0}}, b};
`ifdef VP_SUB_EN
         diff   = a - b;
`endif
         lo     = '0;
         hi     = '0;
         wr_res = 1'b0;
         st_addr[l] = m_addr;
         st_dat[l]  = a;
         if (exec) begin
            case (op_q)
               OP_ADD: begin
                  lo     = sum[WORD_W-1:0];
                  hi     = {{(WORD_W-1){1'b0}}, sum[WORD_W]};
                  wr_res = 1'b1;
               end
               OP_MUL: begin
                  lo     = prod[WORD_W-1:0];
                  hi     = prod[2*WORD_W-1:WORD_W];
                  wr_res = 1'b1;
               end
`ifdef VP_SUB_EN
               OP_SUB: begin
                  lo     = diff;
                  hi     = {WORD_W{(a < b)}};
                  wr_res = 1'b1;
               end
`endif
               OP_LOAD:  rf_d[dst_q][e] = mem[m_addr];
               OP_STORE: st_we = 1'b1;
               default: ;
            endcase
         end
         if (wr_res) begin
            rf_d[LO_R][e] = lo;
            rf_d[HI_R][e] = hi;
         end
      end
   end

   // Register file: cleared on reset, updated lane-wise during EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_q <= '{default: '0};
      end else begin
         rf_q <= rf_d;
      end
   end

   // Main memory is not reset; host port and STORE beats never write in the same cycle.
   always_ff @(posedge clk) begin
      if (host_wr) begin
         mem[host_addr] <= host_wdata;
      end
      if (st_we) begin
         for (int l = 0; l < LANES; l++) begin
            mem[st_addr[l]] <= st_dat[l];
         end
      end
   end

   // Debug read returns the word as it was before this edge's writes.
   always_comb begin
      dbg_rdata_d = dbg_ok ? mem[dbg_addr] : '0;
   end

   // Debug read register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbg_rdata_q <= '0;
      end else begin
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

endmodule

// File: doc/vector_processor_pipe.md
Name: vector_processor_pipe

Overview:
- Parametrised successor to the 4-register, 32-vector processor.
- Same command model: a vector memory plus a small vector register file with load, store, element-wise add and element-wise multiply.
- New in this generation: a valid/ready command handshake and selectable source/destination registers.
- New in this generation: multi-cycle lane-parallel execution (LANES elements per clock), a host write port and a debug read port for memory.

Parameters:
WORD_W, 32, element width in bits
VEC_LEN, 16, elements per vector (word address = vec*VEC_LEN + element)
MEM_VECS, 32, vectors held in main memory
RF_DEPTH, 4, vector registers; results land in rf[RF_DEPTH-2] (low) and rf[RF_DEPTH-1] (high)
LANES, 4, elements processed per clock; VEC_LEN % LANES must be 0; BEATS = VEC_LEN/LANES

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block idle and able to accept a command
opcode  in  3  0 ADD, 1 MUL, 2 LOAD, 3 STORE, 4 SUB (optional), others illegal
src_a  in  clog2(RF_DEPTH)  operand A register / STORE source
src_b  in  clog2(RF_DEPTH)  operand B register
dst  in  clog2(RF_DEPTH)  LOAD destination register
mem_vec  in  clog2(MEM_VECS)  vector index for LOAD/STORE
done  out  1  one-cycle pulse when a command completes
err  out  1  one-cycle pulse with done when the opcode was illegal
host_we  in  1  host word write into memory
host_addr  in  clog2(MEM_VECS*VEC_LEN)  host word address
host_wdata  in  WORD_W  host write data
dbg_addr  in  clog2(MEM_VECS*VEC_LEN)  debug read address
dbg_rdata  out  WORD_W  registered memory word at dbg_addr

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; cmd_ready=1, done=0, err=0, dbg_rdata=0.
  - All rf words are cleared to 0; memory contents are not reset.
  - Reset mid-EXEC abandons the command; partially written beats stay as written.
- FSM IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch opcode/src_a/src_b/dst/mem_vec, clear the beat counter and go to EXEC.
- FSM EXEC:
  - cmd_ready=0.
  - Each clock processes elements [beat*LANES, beat*LANES+LANES-1].
  - On the last beat (beat=BEATS-1), return to IDLE and register done=1 for one cycle.
- Latency: command accepted at edge N; done is high during the cycle after edge N+BEATS (4 cycles by default).
  - cmd_ready rises with done, so back-to-back acceptance on that same cycle is legal.
- LOAD: rf[dst][e] <= mem[mem_vec*VEC_LEN+e].
- STORE: mem[mem_vec*VEC_LEN+e] <= rf[src_a][e].
- ADD: unsigned, s = a+b (WORD_W+1 bits); lo word = s[WORD_W-1:0]; hi word = zero-extended carry (0 or 1).
- MUL: unsigned, p = a*b (2*WORD_W bits); lo word = p low half; hi word = p high half.
- Arithmetic write-back:
  - Results go to rf[RF_DEPTH-2] (lo) and rf[RF_DEPTH-1] (hi).
  - Operands are read from the latched src regs.
  - If a source is also a result register, each element reads its old value: beat k reads only elements it has not yet overwritten.
- Illegal opcode: runs BEATS cycles with no writes; done and err pulse together.
- host_we: writes only while in IDLE and no command is being accepted that cycle; otherwise ignored (dropped, no error).
- dbg_rdata <= mem[dbg_addr] every clock, in any state; it shows memory contents before that edge's writes.
- Addresses: host_addr/dbg_addr values ≥ MEM_VECS*VEC_LEN are ignored for writes and read as 0.

Optional Feature:
- Macro: VP_SUB_EN.
- Defined: opcode 4 = SUB. lo = (a-b) mod 2^WORD_W; hi = all-ones if a<b unsigned, else 0. Write-back and timing are the same as ADD.
- Undefined: opcode 4 is illegal (done+err, no writes).

Test Plan:
- Defaults. Host writes mem[i]=i for i=0..31. LOAD v0→r0, LOAD v1→r1, ADD r0,r1, STORE r2→v31, STORE r3→v30 -> dbg reads give mem[496+e]=2e+16 and mem[480+e]=0. Each done arrives exactly 4 cycles after its accept.
- Host writes mem[i]=2**(i%32) for i=320..351. LOAD v20→r0, LOAD v21→r1, MUL -> mem[256+e] (STORE r2→v16) = 2**(2e+16) for e≤7 and 0 for e≥8. mem[240+e] (STORE r3→v15) = 2**(2e-16) for e≥8 and 0 otherwise.
- ADD with r0[e]=r1[e]=0xFFFFFFFF -> lo = 0xFFFFFFFE, hi = 1.
- cmd_valid held high for 3 commands -> accepts at cycles 0, 5, 10, and cmd_ready is 0 during each EXEC. A host_we during EXEC does not change memory.
- rst_n pulsed low on beat 2 of a STORE -> outputs return to reset values immediately. Elements 0..7 are written, elements 8..15 unchanged; the next command is accepted normally.
- opcode 5, and opcode 4 without VP_SUB_EN -> done+err pulse with no rf or memory change. With VP_SUB_EN, 3-5 gives lo = 0xFFFFFFFE, hi = 0xFFFFFFFF.
